// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register-file write port between
// requesters A and B, with a registered write stage and same-cycle read forwarding.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_data,
   output logic              WE3,
   output logic [ADDR_W-1:0] A3,
   output logic [DATA_W-1:0] WD3,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [DATA_W-1:0] fwd1_data,
   output logic [DATA_W-1:0] fwd2_data
);

   logic r_last;   // 0: A granted most recently, 1: B
   logic w_grant_a;
   logic w_grant_b;
   logic w_xfer_a;
   logic w_xfer_b;

   // On contention the requester not named by r_last wins.
   always_comb begin
      w_grant_a = a_valid & (~b_valid | r_last);
      w_grant_b = b_valid & (~a_valid | ~r_last);
   end

   assign a_ready  = w_grant_a & ~rst;
   assign b_ready  = w_grant_b & ~rst;
   assign w_xfer_a = a_valid & a_ready;
   assign w_xfer_b = b_valid & b_ready;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         WE3    <= 1'b0;
         A3     <= '0;
         WD3    <= '0;
         r_last <= 1'b1;
      end else begin
         WE3 <= 1'b0;
         if (w_xfer_a) begin
            A3     <= a_rd;
            WD3    <= a_data;
            WE3    <= (a_rd != '0);
            r_last <= 1'b0;
         end else if (w_xfer_b) begin
            A3     <= b_rd;
            WD3    <= b_data;
            WE3    <= (b_rd != '0);
            r_last <= 1'b1;
         end
      end
   end

   // The array is written at the end of the cycle WE3 is high, so reads in
   // that cycle take the in-flight value from here.
   assign fwd1_hit  = WE3 & (A3 == rs1) & (rs1 != '0);
   assign fwd2_hit  = WE3 & (A3 == rs2) & (rs2 != '0);
   assign fwd1_data = WD3;
   assign fwd2_data = WD3;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against an architectural
// model: grant order, write stage, x0 drop, forwarding and reset behaviour.
module tb_regfile_wb_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              a_valid, b_valid;
   logic              a_ready, b_ready;
   logic [ADDR_W-1:0] a_rd, b_rd;
   logic [DATA_W-1:0] a_data, b_data;
   logic              WE3;
   logic [ADDR_W-1:0] A3;
   logic [DATA_W-1:0] WD3;
   logic [ADDR_W-1:0] rs1, rs2;
   logic              fwd1_hit, fwd2_hit;
   logic [DATA_W-1:0] fwd1_data, fwd2_data;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .WE3(WE3), .A3(A3), .WD3(WD3),
      .rs1(rs1), .rs2(rs2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
   );

   // Register-file array driven by the DUT write port.
   logic [DATA_W-1:0] tb_rf [32];
   always @(posedge clk) if (WE3 === 1'b1) tb_rf[A3] <= WD3;

   // Reference: who won last, the expected write stage, and architectural
   // register contents (latest accepted non-x0 write per register).
   bit                m_last_b;
   logic              m_we;
   logic [ADDR_W-1:0] m_a3;
   logic [DATA_W-1:0] m_wd;
   logic [DATA_W-1:0] m_arch [32];
   bit                acc_a, acc_b;
   bit                dut_ra, dut_rb;
   int                wait_a, wait_b;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_grant(output bit ga, output bit gb);
      ga = 1'b0;
      gb = 1'b0;
      if (rst !== 1'b0) return;
      if (a_valid && !b_valid)      ga = 1'b1;
      else if (b_valid && !a_valid) gb = 1'b1;
      else if (a_valid && b_valid) begin
         if (m_last_b) ga = 1'b1;
         else          gb = 1'b1;
      end
   endfunction

   task automatic model_edge();
      bit ga, gb;
      model_grant(ga, gb);
      acc_a = ga;
      acc_b = gb;
      if (rst) begin
         m_we = 1'b0; m_a3 = '0; m_wd = '0; m_last_b = 1'b1;
         wait_a = 0; wait_b = 0;
      end else begin
         m_we = 1'b0;
         if (ga) begin
            m_we = (a_rd != 0); m_a3 = a_rd; m_wd = a_data; m_last_b = 1'b0;
            if (a_rd != 0) m_arch[a_rd] = a_data;
         end else if (gb) begin
            m_we = (b_rd != 0); m_a3 = b_rd; m_wd = b_data; m_last_b = 1'b1;
            if (b_rd != 0) m_arch[b_rd] = b_data;
         end
         wait_a = (a_valid && !dut_ra) ? wait_a + 1 : 0;
         wait_b = (b_valid && !dut_rb) ? wait_b + 1 : 0;
      end
   endtask

   // Called 1 time unit after a rising edge; checks at the falling edge.
   task automatic sample();
      bit ga, gb;
      logic [DATA_W-1:0] rv1, rv2;
      #4;
      model_grant(ga, gb);
      dut_ra = a_ready;
      dut_rb = b_ready;
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      chk("one_ready", a_ready & b_ready, 0);
      chk("WE3", WE3, m_we);
      chk("A3", A3, m_a3);
      chk("WD3", WD3, m_wd);
      chk("fwd1_hit", fwd1_hit, m_we && m_a3 == rs1 && rs1 != 0);
      chk("fwd2_hit", fwd2_hit, m_we && m_a3 == rs2 && rs2 != 0);
      chk("fwd1_data", fwd1_data, m_wd);
      chk("fwd2_data", fwd2_data, m_wd);
      rv1 = (rs1 == 0) ? '0 : (fwd1_hit ? fwd1_data : tb_rf[rs1]);
      rv2 = (rs2 == 0) ? '0 : (fwd2_hit ? fwd2_data : tb_rf[rs2]);
      chk("read1", rv1, m_arch[rs1]);
      chk("read2", rv2, m_arch[rs2]);
      if (!rst) begin
         chk("wait_a_bound", wait_a > 1, 0);
         chk("wait_b_bound", wait_b > 1, 0);
      end
   endtask

   task automatic step_edge();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic tick();
      sample();
      step_edge();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         tb_rf[i]  = '0;
         m_arch[i] = '0;
      end
      rst = 1'b1;
      a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h3;
      b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h4;
      rs1 = '0; rs2 = '0;
      step_edge();

      // Reset held with both requesters valid.
      sample();
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      step_edge();
      rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      sample();
      chk("rst_WE3", WE3, 0);
      chk("rst_A3", A3, 0);
      chk("rst_WD3", WD3, 0);
      step_edge();

      // Single write from A.
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h6;
      sample();
      chk("t2_a_ready", a_ready, 1);
      step_edge();
      a_valid = 1'b0; rs1 = 5'd5;
      sample();
      chk("t2_WE3", WE3, 1);
      chk("t2_A3", A3, 5);
      chk("t2_WD3", WD3, 32'h6);
      step_edge();
      tick();
      chk("t2_rf5", tb_rf[5], 32'h6);

      // Contention right after reset: A, B, A, B.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11111111;
      b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h22222222;
      rs1 = 5'd1; rs2 = 5'd2;
      for (int i = 0; i < 4; i++) begin
         sample();
         chk("t3_a_ready", a_ready, (i % 2) == 0);
         chk("t3_b_ready", b_ready, (i % 2) == 1);
         if (i > 0) chk("t3_A3", A3, (i % 2) == 1 ? 1 : 2);
         step_edge();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      sample();
      chk("t3_A3_last", A3, 2);
      step_edge();

      // x0 write is accepted but dropped.
      b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFFFFFF;
      sample();
      chk("t4_b_ready", b_ready, 1);
      step_edge();
      b_valid = 1'b0; rs1 = 5'd0;
      sample();
      chk("t4_WE3", WE3, 0);
      chk("t4_fwd1_hit", fwd1_hit, 0);
      step_edge();
      tick();
      chk("t4_rf0", tb_rf[0], 0);

      // Forwarding of the in-flight write.
      a_valid = 1'b1; a_rd = 5'd6; a_data = 32'hA;
      tick();
      a_valid = 1'b0; rs1 = 5'd6; rs2 = 5'd7;
      sample();
      chk("t5_fwd1_hit", fwd1_hit, 1);
      chk("t5_fwd1_data", fwd1_data, 32'hA);
      chk("t5_fwd2_hit", fwd2_hit, 0);
      step_edge();

      // Reset while a write is in flight and B is waiting.
      a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
      tick();
      a_valid = 1'b0; rst = 1'b1;
      b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h33;
      sample();
      chk("t6_WE3_inflight", WE3, 1);
      chk("t6_b_ready_rst", b_ready, 0);
      step_edge();
      rst = 1'b0;
      sample();
      chk("t6_WE3_cleared", WE3, 0);
      chk("t6_b_first", b_ready, 1);
      step_edge();
      b_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
      sample();
      chk("t6_a_wins", a_ready, 1);
      chk("t6_b_loses", b_ready, 0);
      step_edge();
      a_valid = 1'b0; b_valid = 1'b0;
      tick();

      // Randomized traffic with held requests and occasional reset.
      for (int n = 0; n < 400; n++) begin
         if (acc_a) a_valid = 1'b0;
         if (acc_b) b_valid = 1'b0;
         if (!a_valid && $urandom_range(0, 3) != 0) begin
            a_valid = 1'b1; a_rd = 5'($urandom_range(0, 7)); a_data = $urandom;
         end
         if (!b_valid && $urandom_range(0, 3) != 0) begin
            b_valid = 1'b1; b_rd = 5'($urandom_range(0, 7)); b_data = $urandom;
         end
         rst = ($urandom_range(0, 49) == 0);
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
